// File: rtl/bcrypt_proxy_reader_pkg.sv
// Shared constants and helpers for the bcrypt proxy output path.
// The proxy reader and its serial receiver import this package.
package bcrypt_proxy_reader_pkg;

  // Maximum number of cycles to wait for a start bit after a proxy read strobe.
  localparam int PROXY_RD_START_TIMEOUT = 16;

  // Returns the index of the highest set bit. msb(0) is 0, so msb(n-1)+1 is
  // the width needed to hold the values 0..n-1.
  function automatic int msb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_pkt_rx.sv
// Receives one framed serial packet: waits a bounded time for the start bit,
// then shifts in PKT_BITS data bits LSB-first.
module serial_pkt_rx #(
  parameter int PKT_BITS      = 64,
  parameter int START_TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                start,
  input  logic                din,
  output logic [PKT_BITS-1:0] pkt,
  output logic                done,
  output logic                timeout
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam int BIT_W = $clog2(PKT_BITS + 1);

  localparam logic [1:0] RX_IDLE    = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] SHIFT      = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [PKT_BITS-1:0] shreg;
  logic                last_wait;
  logic                last_bit;

  assign last_wait = (wait_cnt == CNT_W'(START_TIMEOUT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(PKT_BITS - 1));

  // done and timeout flag the cycle of the deciding sample so the parent can
  // register its outputs on that same edge; a start bit beats the timeout.
  assign done    = (state == SHIFT) && last_bit;
  assign timeout = (state == WAIT_START) && !din && last_wait;

  // During the final sample, present the packet including the bit in flight.
  assign pkt = done ? {din, shreg[PKT_BITS-1:1]} : shreg;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RX_IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      // NOTE: the packet register is reset as well; it is plain flops, not a
      // RAM, and a cleared value keeps pkt deterministic after reset.
      shreg    <= '0;
    end else if (start) begin
      state    <= WAIT_START;
      wait_cnt <= '0;
    end else begin
      case (state)
        WAIT_START: begin
          if (din) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end else if (last_wait) begin
            state <= RX_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SHIFT: begin
          shreg   <= {din, shreg[PKT_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bcrypt_proxy_reader.sv
// Round-robin collector: strobes one non-empty proxy, receives its serial
// packet and streams it out as bytes over a valid/ready handshake.
module bcrypt_proxy_reader
  import bcrypt_proxy_reader_pkg::*;
#(
  parameter int NUM_PROXIES   = 2,
  parameter int PKT_BITS      = 64,
  parameter int START_TIMEOUT = PROXY_RD_START_TIMEOUT
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [NUM_PROXIES-1:0]            proxy_empty,
  output logic [NUM_PROXIES-1:0]            proxy_rd_en,
  input  logic [NUM_PROXIES-1:0]            proxy_dout,
  output logic [7:0]                        dout,
  output logic                              dout_valid,
  output logic                              dout_last,
  input  logic                              dout_ready,
  output logic [msb(NUM_PROXIES-1):0]       src_proxy,
  output logic                              err_timeout
);

  localparam int PTR_W  = msb(NUM_PROXIES - 1) + 1;
  localparam int NBYTES = PKT_BITS / 8;
  localparam int IDX_W  = msb(NBYTES - 1) + 1;

  // WAIT_START and SHIFT live inside the receiver; RECV covers both here.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] RECV   = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  logic [1:0]          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    sel;
  logic [IDX_W-1:0]    idx;
  logic [PKT_BITS-1:0] rx_pkt;
  logic                rx_done;
  logic                rx_timeout;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PROXIES - 1)) ? '0 : p + 1'b1;
  endfunction

  serial_pkt_rx #(
    .PKT_BITS      (PKT_BITS),
    .START_TIMEOUT (START_TIMEOUT)
  ) u_rx (
    .CLK     (CLK),
    .nRST    (nRST),
    .start   (state == STROBE),
    .din     (proxy_dout[sel]),
    .pkt     (rx_pkt),
    .done    (rx_done),
    .timeout (rx_timeout)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      ptr         <= '0;
      sel         <= '0;
      idx         <= '0;
      proxy_rd_en <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      src_proxy   <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (!proxy_empty[ptr]) begin
            sel         <= ptr;
            proxy_rd_en <= NUM_PROXIES'(1) << ptr;
            state       <= STROBE;
          end else begin
            ptr <= wrap_inc(ptr);
          end
        end
        STROBE: begin
          proxy_rd_en <= '0;
          state       <= RECV;
        end
        RECV: begin
          if (rx_done) begin
            dout       <= rx_pkt[7:0];
            dout_valid <= 1'b1;
            dout_last  <= (NBYTES == 1);
            idx        <= '0;
            src_proxy  <= sel;
            state      <= OUT;
          end else if (rx_timeout) begin
            err_timeout <= 1'b1;
            ptr         <= wrap_inc(sel);
            state       <= IDLE;
          end
        end
        OUT: begin
          if (dout_ready) begin
            if (dout_last) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              ptr        <= wrap_inc(sel);
              state      <= IDLE;
            end else begin
              // The receiver holds the packet until the next strobe, so bytes
              // are read straight from it.
              idx       <= idx + 1'b1;
              dout      <= rx_pkt[8*(int'(idx)+1) +: 8];
              dout_last <= (int'(idx) + 2 == NBYTES);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcrypt_proxy_reader.md
# bcrypt_proxy_reader

Arbiter-side collector that drains result packets from a group of bcrypt proxies over their serial output handshake (`empty`/`rd_en`/1-bit `dout`). It polls the proxies round-robin, issues a single-cycle read strobe to one non-empty proxy, captures the framed serial packet and deserializes it. It then streams the packet to the output arbiter as bytes with a valid/ready handshake. The block sits between the proxies' output ports and the result FIFO of the bcrypt arbiter.

## Interface
Parameters:
- `NUM_PROXIES`, 2: number of proxies served, range 1..16.
- `PKT_BITS`, 64: data bits per packet; must be a multiple of 8.
- `START_TIMEOUT`, 16: maximum number of cycles to wait for the start bit after `rd_en`.

Ports:
- `CLK` in 1: single clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `proxy_empty` in NUM_PROXIES: per-proxy "no packet ready", active high.
- `proxy_rd_en` out NUM_PROXIES: one-hot read strobe, one cycle long.
- `proxy_dout` in NUM_PROXIES: per-proxy serial data.
- `dout` out 8: output byte.
- `dout_valid` out 1: `dout` is valid.
- `dout_last` out 1: this byte is the last byte of the packet.
- `dout_ready` in 1: consumer accepts the byte.
- `src_proxy` out `MSB(NUM_PROXIES-1)+1`: index of the proxy that sourced the current packet; stable while `dout_valid` is high.
- `err_timeout` out 1: one-cycle pulse when the start bit is missing.

## Operation
- Serial frame on the selected proxy's `dout`:
  - Idle level is 0.
  - A start bit of 1 follows `rd_en`.
  - Then `PKT_BITS` data bits, LSB-first, one bit per cycle, with no gaps.
- FSM states: IDLE, STROBE, WAIT_START, SHIFT, OUT.
- IDLE:
  - Scan `proxy_empty[ptr]`. If it is 0, latch `sel <= ptr` and go to STROBE.
  - Otherwise advance `ptr`, wrapping from `NUM_PROXIES-1` to 0. The scan checks one proxy per cycle.
- STROBE:
  - Assert `proxy_rd_en[sel]` for exactly this cycle.
  - Clear the timeout counter and go to WAIT_START.
- WAIT_START:
  - Sample `proxy_dout[sel]` each cycle.
  - On 1: clear the bit counter and go to SHIFT.
  - If `START_TIMEOUT` cycles pass without a start bit: pulse `err_timeout`, advance `ptr` past `sel`, and return to IDLE. No output is produced.
- SHIFT:
  - Shift each sampled bit into a `PKT_BITS` register at the MSB end, right-shifting, so the first data bit ends up at bit 0.
  - After `PKT_BITS` samples, go to OUT with the byte index at 0.
- OUT:
  - Drive `dout = pkt[8*idx +: 8]`, `dout_valid = 1`, and `dout_last = (idx == PKT_BITS/8-1)`.
  - On `dout_valid & dout_ready`, increment `idx`.
  - After the last byte is accepted, advance `ptr` to `sel+1` (with wrap) and return to IDLE.
- Only one packet is in flight at a time. No proxy is strobed while the block is in OUT, so back-pressure stalls every proxy.
- `proxy_dout` bits for unselected proxies are ignored.
- The scan pointer gives fairness: after serving proxy k, scanning restarts at k+1.

## Timing
- Reset values:
  - `proxy_rd_en = 0`, `dout = 0`, `dout_valid = 0`, `dout_last = 0`, `src_proxy = 0`, `err_timeout = 0`.
  - State IDLE, `ptr = 0`.
- All outputs are registered.
- Latency:
  - `proxy_rd_en` is high one cycle after the cycle in which IDLE sees `proxy_empty[ptr] = 0`.
  - The start bit is accepted at the earliest in the cycle after the `rd_en` cycle.
  - The first `dout_valid` appears 1 cycle after the last data bit is sampled.
- Byte throughput in OUT is 1 per cycle while `dout_ready` stays high. `dout` and `dout_last` hold while `dout_ready` is low.
- `proxy_rd_en` is never asserted on two consecutive cycles. At least `START_TIMEOUT` or `PKT_BITS+1` cycles separate strobes, which covers the proxy's post-read delay.
- Reset asserted mid-packet:
  - All outputs clear immediately (asynchronous reset).
  - The partially received packet is discarded and the FSM returns to IDLE.
- If `proxy_empty[sel]` rises during WAIT_START or SHIFT, it is ignored.
- If a 1 appears in the same cycle the timeout expires, the start bit wins.

## Structure
- The shared `bcrypt.vh` holds `MSB()` and the new constant `PROXY_RD_START_TIMEOUT` (16).
- One sub-module, `serial_pkt_rx`, holds WAIT_START/SHIFT, the timeout counter and the shift register. Its ports are `CLK`, `nRST`, `start`, `din`, `pkt`, `done`, `timeout`.
- The top level owns the scan, strobe and byte-output logic.

## Test plan
- Single packet: `NUM_PROXIES = 2`, proxy 1 non-empty, serial frame 1 followed by 0x0123456789ABCDEF LSB-first → `proxy_rd_en = 2'b10` for exactly one cycle; output bytes EF,CD,AB,89,67,45,23,01; `dout_last` only on 01; `src_proxy = 1`.
- Fairness: both proxies permanently non-empty, `dout_ready = 1` → strobes alternate 0,1,0,1 over 4 packets.
- Back-pressure: `dout_ready` toggles 1,0,0,1 → each byte is held until accepted; no new `proxy_rd_en` until the last byte is accepted.
- Timeout: proxy 0 non-empty but `proxy_dout` stays 0 → `err_timeout` pulses exactly `START_TIMEOUT` cycles after the WAIT_START entry; no `dout_valid`; next scan starts at proxy 1.
- Late start bit: start bit on the 16th WAIT_START cycle → packet is accepted with no error.
- Reset mid-SHIFT: `nRST` low for 1 cycle after 30 data bits → outputs are 0 immediately; a following full packet is received intact.
